// File: rtl/apb3_cmd_master.sv
// APB3 initiator: turns a valid/ready command into one APB3 read or write
// transfer and returns read data and error/timeout status on a held response.
module apb3_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // SETUP  | APB setup phase (PSEL=1, PENABLE=0)
  // ACCESS | APB access phase, waiting for PREADY or timeout
  // RESP   | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  // Counter is at least 8 bits and widens to hold TIMEOUT_CYCLES.
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TC_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  tmo_hit;

  // The abort lands on the T-th consecutive edge that samples PREADY low.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TC_LAST);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= S_IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          pwrite_d   = cmd_write;
          wait_cnt_d = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          err_d   = PSLVERR;
          rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE) && PRESETN;
  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS);
  assign rsp_valid   = (state_q == S_RESP);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule
